// File: rtl/asconp_iter_if.sv
// Request/result bus of the iterative Ascon permutation engine.
// Handshake: a transfer happens on a rising clk edge where valid and ready
// are both high. The producer keeps valid high until it is accepted; the
// engine holds out_valid and x*_o unchanged until out_ready is seen high.
// in_valid is ignored in any cycle where in_ready is low.
interface asconp_iter_if;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  rounds_i;
  logic [63:0] x0_i, x1_i, x2_i, x3_i, x4_i;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] x0_o, x1_o, x2_o, x3_o, x4_o;
  logic        busy;
  logic [1:0]  state_dbg;

  // Controller side
  modport master (
    output in_valid, rounds_i, x0_i, x1_i, x2_i, x3_i, x4_i, out_ready,
    input  in_ready, out_valid, x0_o, x1_o, x2_o, x3_o, x4_o, busy, state_dbg
  );

  // Engine side
  modport slave (
    input  in_valid, rounds_i, x0_i, x1_i, x2_i, x3_i, x4_i, out_ready,
    output in_ready, out_valid, x0_o, x1_o, x2_o, x3_o, x4_o, busy, state_dbg
  );
endinterface

// File: rtl/asconp_iter.sv
// Iterative Ascon permutation: UROL rounds per clock, 0..12 rounds per
// request. Rounds past the last one in the final cycle pass the state through.
module asconp_iter #(
  parameter int UROL       = 1,
  parameter int MAX_ROUNDS = 12
) (
  input logic         clk,
  input logic         rst_n,
  asconp_iter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } fsm_t;

  // Word 0 is x0 ... word 4 is x4
  typedef logic [0:4][63:0] st_t;

  fsm_t       state_q, state_d;
  st_t        x_q, x_d, stage;
  logic [4:0] rc_q, rc_d;
  logic [4:0] rc_sum;
  logic [3:0] r_clamp;
  logic       ready;

  function automatic logic [63:0] rotr(input logic [63:0] w, input int n);
    return (w >> n) | (w << (64 - n));
  endfunction

  // One Ascon round: constant addition, bitsliced S-box, linear diffusion
  function automatic st_t ascon_round(input st_t s, input logic [3:0] j);
    logic [63:0] a0, a1, a2, a3, a4;
    logic [63:0] t0, t1, t2, t3, t4;
    st_t r;
    a0 = s[0]; a1 = s[1]; a2 = s[2]; a3 = s[3]; a4 = s[4];
    a2 = a2 ^ {56'd0, 4'hF - j, j};
    a0 = a0 ^ a4; a4 = a4 ^ a3; a2 = a2 ^ a1;
    t0 = ~a0 & a1; t1 = ~a1 & a2; t2 = ~a2 & a3; t3 = ~a3 & a4; t4 = ~a4 & a0;
    a0 = a0 ^ t1; a1 = a1 ^ t2; a2 = a2 ^ t3; a3 = a3 ^ t4; a4 = a4 ^ t0;
    a1 = a1 ^ a0; a0 = a0 ^ a4; a3 = a3 ^ a2; a2 = ~a2;
    r[0] = a0 ^ rotr(a0, 19) ^ rotr(a0, 28);
    r[1] = a1 ^ rotr(a1, 61) ^ rotr(a1, 39);
    r[2] = a2 ^ rotr(a2, 1)  ^ rotr(a2, 6);
    r[3] = a3 ^ rotr(a3, 10) ^ rotr(a3, 17);
    r[4] = a4 ^ rotr(a4, 7)  ^ rotr(a4, 41);
    return r;
  endfunction

  // Unrolled round chain; stages whose index reaches 12 are bypassed
  always_comb begin
    logic [4:0] j5;
    stage = x_q;
    j5    = 5'd0;
    for (int k = 0; k < UROL; k++) begin
      j5 = rc_q + 5'(k);
      if (j5 < 5'd12) stage = ascon_round(stage, j5[3:0]);
    end
  end

  // Requested round count clamped to the permutation maximum
  always_comb begin
    r_clamp = (bus.rounds_i > 4'(MAX_ROUNDS)) ? 4'(MAX_ROUNDS) : bus.rounds_i;
    rc_sum  = rc_q + 5'(UROL);
  end

  // Next-state, round counter and state-word update
  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    rc_d    = rc_q;
    ready   = 1'b0;
    case (state_q)
      IDLE: ready = 1'b1;
      RUN: begin
        x_d = stage;
        if (rc_sum >= 5'd12) begin
          rc_d    = 5'd12;
          state_d = DONE;
        end else begin
          rc_d = rc_sum;
        end
      end
      DONE: begin
        ready = bus.out_ready;
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (bus.in_valid && ready) begin
      x_d     = {bus.x0_i, bus.x1_i, bus.x2_i, bus.x3_i, bus.x4_i};
      rc_d    = 5'd12 - {1'b0, r_clamp};
      state_d = (r_clamp == 4'd0) ? DONE : RUN;
    end
  end

  // State register, round counter and permutation state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      x_q     <= '0;
      rc_q    <= 5'd0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      rc_q    <= rc_d;
    end
  end

  assign bus.in_ready  = ready;
  assign bus.out_valid = (state_q == DONE);
  assign bus.busy      = (state_q != IDLE);
  assign bus.state_dbg = state_q;
  assign bus.x0_o      = x_q[0];
  assign bus.x1_o      = x_q[1];
  assign bus.x2_o      = x_q[2];
  assign bus.x3_o      = x_q[3];
  assign bus.x4_o      = x_q[4];

endmodule
